// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID latch: owns the PC, applies EX redirects,
// holds on load-use hazards and tells ID when to bubble ID/EX.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    input  logic             ex_jump,
    input  logic [31:0]      ex_jump_target,
    input  logic             id_ex_memtoreg,
    input  logic             id_ex_regwr,
    input  logic [4:0]       id_ex_rt,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic        redirect;
    logic        hazard;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    always_comb begin
        redirect = ex_branch_taken | ex_jump;
        target   = ex_branch_taken ? ex_branch_target : ex_jump_target;
        pc_plus4 = pc_q + 32'd4;
        // Register 0 is an ordinary register here, so it takes part in the match.
        hazard   = valid_q & id_ex_memtoreg & id_ex_regwr &
                   ((id_ex_rt == instr_q[25:21]) | (id_ex_rt == instr_q[20:16]));
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (redirect) begin
            pc_d    = target;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            if (flush_q != '1) begin
                flush_d = flush_q + CNT_ONE;
            end
        end else if (hazard) begin
            if (stall_q != '1) begin
                stall_d = stall_q + CNT_ONE;
            end
        end else begin
            pc_d    = pc_plus4;
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign imem_addr    = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;
    assign stall_cnt    = stall_q;
    assign flush_cnt    = flush_q;
    // Wrong-path kill on redirect, load-use bubble on hazard, and nothing real in ID.
    assign id_ex_bubble = redirect | hazard | ~valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for wrap,
// saturation and reset corners, then random stimulus against a reference model.
module tb_fetch_stage;

    logic        CLK;
    logic        RESET;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        ex_jump;
    logic [31:0] ex_jump_target;
    logic        id_ex_memtoreg;
    logic        id_ex_regwr;
    logic [4:0]  id_ex_rt;

    logic [31:0] imem_addr0, imem_data0, if_id_instr0, if_id_pc40;
    logic        if_id_valid0, id_ex_bubble0;
    logic [15:0] stall_cnt0, flush_cnt0;

    logic [31:0] imem_addr1, imem_data1, if_id_instr1, if_id_pc41;
    logic        if_id_valid1, id_ex_bubble1;
    logic [1:0]  stall_cnt1, flush_cnt1;

    int nchecks = 0;
    int nerr    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [4:0] rs;
        logic [4:0] rt;
        rs = a[6:2];
        rt = rs + 5'd5;
        return {6'h23, rs, rt, a[15:0]};
    endfunction

    assign imem_data0 = mem_word(imem_addr0);
    assign imem_data1 = mem_word(imem_addr1);

    fetch_stage dut0 (
        .CLK(CLK), .RESET(RESET),
        .imem_addr(imem_addr0), .imem_data(imem_data0),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .ex_jump(ex_jump), .ex_jump_target(ex_jump_target),
        .id_ex_memtoreg(id_ex_memtoreg), .id_ex_regwr(id_ex_regwr), .id_ex_rt(id_ex_rt),
        .if_id_instr(if_id_instr0), .if_id_pc4(if_id_pc40), .if_id_valid(if_id_valid0),
        .id_ex_bubble(id_ex_bubble0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .imem_addr(imem_addr1), .imem_data(imem_data1),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .ex_jump(ex_jump), .ex_jump_target(ex_jump_target),
        .id_ex_memtoreg(id_ex_memtoreg), .id_ex_regwr(id_ex_regwr), .id_ex_rt(id_ex_rt),
        .if_id_instr(if_id_instr1), .if_id_pc4(if_id_pc41), .if_id_valid(if_id_valid1),
        .id_ex_bubble(id_ex_bubble1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: architectural view of one fetch stage.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        int unsigned stall;
        int unsigned flush;
    } mstate_t;

    mstate_t m0 = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, stall: 0, flush: 0};
    mstate_t m1 = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, stall: 0, flush: 0};

    function automatic bit model_hazard(input mstate_t s);
        bit uses_rt;
        uses_rt = (s.instr[25:21] == id_ex_rt) || (s.instr[20:16] == id_ex_rt);
        return s.valid && id_ex_memtoreg && id_ex_regwr && uses_rt;
    endfunction

    function automatic bit model_bubble(input mstate_t s);
        return ex_branch_taken || ex_jump || model_hazard(s) || !s.valid;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input int unsigned maxc,
                                           input logic [31:0] rpc);
        mstate_t n;
        n = s;
        if (RESET) begin
            n = '{pc: rpc, instr: 32'h0, pc4: 32'h0, valid: 1'b0, stall: 0, flush: 0};
        end else if (ex_branch_taken || ex_jump) begin
            n.pc    = ex_branch_taken ? ex_branch_target : ex_jump_target;
            n.instr = 32'h0;
            n.pc4   = 32'h0;
            n.valid = 1'b0;
            n.flush = (s.flush < maxc) ? s.flush + 1 : maxc;
        end else if (model_hazard(s)) begin
            n.stall = (s.stall < maxc) ? s.stall + 1 : maxc;
        end else begin
            n.pc    = s.pc + 32'd4;
            n.instr = mem_word(s.pc);
            n.pc4   = s.pc + 32'd4;
            n.valid = 1'b1;
        end
        return n;
    endfunction

    always @(posedge CLK) begin
        m0 <= model_step(m0, 65535, 32'h0000_0000);
        m1 <= model_step(m1, 3, 32'hFFFF_FFF8);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic rst, input logic bt, input logic [31:0] btgt,
                          input logic j, input logic [31:0] jtgt,
                          input logic m2r, input logic rw, input logic [4:0] rt);
        RESET = rst; ex_branch_taken = bt; ex_branch_target = btgt;
        ex_jump = j; ex_jump_target = jtgt;
        id_ex_memtoreg = m2r; id_ex_regwr = rw; id_ex_rt = rt;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmp_model();
        chk("m0.pc",     imem_addr0,             m0.pc);
        chk("m0.instr",  if_id_instr0,           m0.instr);
        chk("m0.pc4",    if_id_pc40,             m0.pc4);
        chk("m0.valid",  {31'b0, if_id_valid0},  {31'b0, m0.valid});
        chk("m0.bubble", {31'b0, id_ex_bubble0}, {31'b0, model_bubble(m0)});
        chk("m0.stall",  {16'b0, stall_cnt0},    m0.stall);
        chk("m0.flush",  {16'b0, flush_cnt0},    m0.flush);
        chk("m1.pc",     imem_addr1,             m1.pc);
        chk("m1.instr",  if_id_instr1,           m1.instr);
        chk("m1.pc4",    if_id_pc41,             m1.pc4);
        chk("m1.valid",  {31'b0, if_id_valid1},  {31'b0, m1.valid});
        chk("m1.bubble", {31'b0, id_ex_bubble1}, {31'b0, model_bubble(m1)});
        chk("m1.stall",  {30'b0, stall_cnt1},    m1.stall);
        chk("m1.flush",  {30'b0, flush_cnt1},    m1.flush);
    endtask

    typedef struct {
        logic        rst;
        logic        bt;
        logic [31:0] btgt;
        logic        j;
        logic [31:0] jtgt;
        logic        m2r;
        logic        rw;
        logic [4:0]  rt;
        logic        bub;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        int unsigned stall;
        int unsigned flush;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic bt, input logic [31:0] btgt,
                                 input logic j, input logic [31:0] jtgt, input logic m2r,
                                 input logic rw, input logic [4:0] rt, input logic bub,
                                 input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [31:0] pc4, input logic valid,
                                 input int unsigned stall, input int unsigned flush);
        vec_t v;
        v.rst = rst; v.bt = bt; v.btgt = btgt; v.j = j; v.jtgt = jtgt;
        v.m2r = m2r; v.rw = rw; v.rt = rt; v.bub = bub; v.pc = pc; v.instr = instr;
        v.pc4 = pc4; v.valid = valid; v.stall = stall; v.flush = flush;
        return v;
    endfunction

    vec_t vecs[17];

    initial begin
        //           rst bt btgt     j  jtgt     m2r rw rt  bub  pc        instr                 pc4       v  st fl
        vecs[0]  = mkv(1, 0, 32'h0,  0, 32'h0,   0, 0, 5'd0,  1, 32'h0,   32'h0,                32'h0,    0, 0, 0);
        vecs[1]  = mkv(0, 0, 32'h0,  0, 32'h0,   0, 0, 5'd0,  1, 32'h4,   mem_word(32'h0),      32'h4,    1, 0, 0);
        vecs[2]  = mkv(0, 0, 32'h0,  0, 32'h0,   0, 0, 5'd0,  0, 32'h8,   mem_word(32'h4),      32'h8,    1, 0, 0);
        vecs[3]  = mkv(0, 0, 32'h0,  0, 32'h0,   0, 0, 5'd0,  0, 32'hC,   mem_word(32'h8),      32'hC,    1, 0, 0);
        vecs[4]  = mkv(0, 0, 32'h0,  0, 32'h0,   1, 1, 5'd7,  1, 32'hC,   mem_word(32'h8),      32'hC,    1, 1, 0);
        vecs[5]  = mkv(0, 0, 32'h0,  0, 32'h0,   1, 1, 5'd6,  0, 32'h10,  mem_word(32'hC),      32'h10,   1, 1, 0);
        vecs[6]  = mkv(0, 1, 32'h40, 0, 32'h0,   0, 0, 5'd0,  1, 32'h40,  32'h0,                32'h0,    0, 1, 1);
        vecs[7]  = mkv(0, 0, 32'h0,  0, 32'h0,   0, 0, 5'd0,  1, 32'h44,  mem_word(32'h40),     32'h44,   1, 1, 1);
        vecs[8]  = mkv(0, 0, 32'h0,  0, 32'h0,   0, 0, 5'd0,  0, 32'h48,  mem_word(32'h44),     32'h48,   1, 1, 1);
        vecs[9]  = mkv(0, 1, 32'h80, 1, 32'h200, 1, 1, 5'd17, 1, 32'h80,  32'h0,                32'h0,    0, 1, 2);
        vecs[10] = mkv(0, 0, 32'h0,  0, 32'h0,   1, 1, 5'd0,  1, 32'h84,  mem_word(32'h80),     32'h84,   1, 1, 2);
        vecs[11] = mkv(0, 0, 32'h0,  1, 32'h100, 0, 0, 5'd0,  1, 32'h100, 32'h0,                32'h0,    0, 1, 3);
        vecs[12] = mkv(0, 0, 32'h0,  0, 32'h0,   1, 0, 5'd0,  1, 32'h104, mem_word(32'h100),    32'h104,  1, 1, 3);
        vecs[13] = mkv(0, 0, 32'h0,  0, 32'h0,   1, 0, 5'd0,  0, 32'h108, mem_word(32'h104),    32'h108,  1, 1, 3);
        vecs[14] = mkv(1, 0, 32'h0,  0, 32'h0,   1, 1, 5'd6,  1, 32'h0,   32'h0,                32'h0,    0, 0, 0);
        vecs[15] = mkv(0, 0, 32'h0,  0, 32'h0,   0, 0, 5'd0,  1, 32'h4,   mem_word(32'h0),      32'h4,    1, 0, 0);
        vecs[16] = mkv(1, 1, 32'h40, 0, 32'h0,   0, 0, 5'd0,  1, 32'h0,   32'h0,                32'h0,    0, 0, 0);

        set_in(1, 0, 32'h0, 0, 32'h0, 0, 0, 5'd0);
        tick();
        tick();

        for (int i = 0; i < 17; i++) begin
            set_in(vecs[i].rst, vecs[i].bt, vecs[i].btgt, vecs[i].j, vecs[i].jtgt,
                   vecs[i].m2r, vecs[i].rw, vecs[i].rt);
            @(negedge CLK);
            chk($sformatf("vec%0d.bubble", i), {31'b0, id_ex_bubble0}, {31'b0, vecs[i].bub});
            tick();
            chk($sformatf("vec%0d.pc", i),    imem_addr0,            vecs[i].pc);
            chk($sformatf("vec%0d.instr", i), if_id_instr0,          vecs[i].instr);
            chk($sformatf("vec%0d.pc4", i),   if_id_pc40,            vecs[i].pc4);
            chk($sformatf("vec%0d.valid", i), {31'b0, if_id_valid0}, {31'b0, vecs[i].valid});
            chk($sformatf("vec%0d.stall", i), {16'b0, stall_cnt0},   vecs[i].stall);
            chk($sformatf("vec%0d.flush", i), {16'b0, flush_cnt0},   vecs[i].flush);
        end

        // PC wrap on the instance reset to FFFF_FFF8.
        set_in(1, 0, 32'h0, 0, 32'h0, 0, 0, 5'd0);
        tick();
        chk("wrap.reset_pc", imem_addr1, 32'hFFFF_FFF8);
        set_in(0, 0, 32'h0, 0, 32'h0, 0, 0, 5'd0);
        tick();
        chk("wrap.pc_fffc", imem_addr1, 32'hFFFF_FFFC);
        chk("wrap.instr",   if_id_instr1, mem_word(32'hFFFF_FFF8));
        tick();
        chk("wrap.pc_0",    imem_addr1, 32'h0);
        chk("wrap.pc4_0",   if_id_pc41, 32'h0);

        // Held load-use hazard saturates the 2-bit stall counter at 3.
        set_in(0, 0, 32'h0, 0, 32'h0, 1, 1, 5'd31);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            chk($sformatf("sat%0d.bubble", k), {31'b0, id_ex_bubble1}, 32'h1);
            tick();
            chk($sformatf("sat%0d.stall", k), {30'b0, stall_cnt1}, (k < 3) ? k : 3);
            chk($sformatf("sat%0d.pc", k),    imem_addr1, 32'h0);
        end

        // Reset asserted during a stall cycle.
        set_in(1, 0, 32'h0, 0, 32'h0, 1, 1, 5'd31);
        tick();
        chk("rststall.pc",    imem_addr1, 32'hFFFF_FFF8);
        chk("rststall.stall", {30'b0, stall_cnt1}, 32'h0);
        chk("rststall.valid", {31'b0, if_id_valid1}, 32'h0);

        // Random stimulus against the reference model.
        for (int c = 0; c < 600; c++) begin
            set_in(($urandom_range(0, 40) == 0),
                   ($urandom_range(0, 7) == 0), $urandom,
                   ($urandom_range(0, 7) == 0), $urandom,
                   ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
                   5'($urandom_range(0, 31)));
            @(negedge CLK);
            cmp_model();
            tick();
        end
        @(negedge CLK);
        cmp_model();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline latch with load-use stall and branch/jump flush control. Sits directly upstream of the ID decode logic that feeds `id_ex_register`. Owns the program counter, drives the external instruction-memory address, and latches the fetched word for ID. Tells ID when to inject a bubble into ID/EX.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, default 16: width of the saturating stall and flush counters.

Ports:
- `CLK`  in  1  — single clock; all state updates on posedge.
- `RESET`  in  1  — synchronous, active-high reset.
- `imem_addr`  out  32  — equals current PC; instruction memory reads combinationally.
- `imem_data`  in  32  — instruction word at `imem_addr`.
- `ex_branch_taken`  in  1  — taken branch resolved in EX this cycle.
- `ex_branch_target`  in  32  — branch target address.
- `ex_jump`  in  1  — jump in EX this cycle.
- `ex_jump_target`  in  32  — jump target address.
- `id_ex_memtoreg`  in  1  — instruction now in EX is a load.
- `id_ex_regwr`  in  1  — instruction now in EX writes a register.
- `id_ex_rt`  in  5  — load destination register in EX.
- `if_id_instr`  out  32  — latched instruction for ID.
- `if_id_pc4`  out  32  — latched PC+4 of that instruction.
- `if_id_valid`  out  1  — latched instruction is real, not a flush NOP.
- `id_ex_bubble`  out  1  — ID must write all-zero control into ID/EX this cycle.
- `stall_cnt`  out  CNT_W  — saturating count of load-use stall cycles.
- `flush_cnt`  out  CNT_W  — saturating count of redirect cycles.

## Operation
- Redirect: `redirect = ex_branch_taken | ex_jump`.
  - Target is `ex_branch_target` if `ex_branch_taken`, else `ex_jump_target`. Branch wins if both are asserted.
- Hazard: `hazard = if_id_valid & id_ex_memtoreg & id_ex_regwr & (id_ex_rt == if_id_instr[25:21] | id_ex_rt == if_id_instr[20:16])`.
  - No special case for register 0. Register 0 is not hardwired to zero in this design.
- Next state, in priority order:
  - `RESET`: PC←RESET_PC; if_id_instr←0; if_id_pc4←0; if_id_valid←0; both counters←0.
  - `redirect`: PC←target; if_id_instr←0; if_id_pc4←0; if_id_valid←0; flush_cnt++ (saturating). Redirect overrides `hazard`.
  - `hazard`: PC, if_id_instr, if_id_pc4 and if_id_valid all hold; stall_cnt++ (saturating).
  - Otherwise: PC←PC+4; if_id_instr←imem_data; if_id_pc4←PC+4; if_id_valid←1.
- `id_ex_bubble = redirect | hazard | ~if_id_valid`, combinational.
  - On redirect this kills the wrong-path instruction in ID.
  - On hazard it inserts the load-use bubble.
- PC+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0. Low two PC bits are not checked; targets are used as given.
- Counters stick at all-ones once reached.

## Timing
- Reset values: imem_addr=RESET_PC; if_id_instr=0; if_id_pc4=0; if_id_valid=0; stall_cnt=0; flush_cnt=0.
- id_ex_bubble=1 during and directly after reset, because valid=0.
- Fetch latency: a word presented at `imem_addr` in cycle N appears on `if_id_instr` after posedge N.
- Load-use stall: exactly one cycle per load. After the stall edge the load leaves EX, so `hazard` drops unless a new load has entered EX.
- Redirect: PC equals target after the edge of the redirect cycle. Exactly two wrong-path slots are squashed:
  - the IF/ID latch, which is cleared;
  - the ID instruction, which is bubbled.
- RESET asserted mid-stall or mid-redirect: reset wins at that edge; all state takes reset values.
- All outputs except `id_ex_bubble` are registered, or are PC directly.

## Test plan
- Reset then free run, with imem_data = addr-derived words:
  - PC sequence 0,4,8,C.
  - if_id_pc4 = 4 one cycle after PC=0.
  - if_id_valid rises on the first post-reset edge.
  - id_ex_bubble=1 only in the first cycle.
- Load-use: id_ex_memtoreg=1, id_ex_regwr=1, id_ex_rt=5, if_id_instr[20:16]=5 for one cycle:
  - PC and if_id_instr hold one cycle.
  - id_ex_bubble=1 that cycle.
  - stall_cnt=1.
  - Repeat with rt=6 and no match: no stall.
- Branch taken, target 32'h40, at PC=0x10:
  - next PC=0x40; if_id_valid=0; if_id_instr=0.
  - id_ex_bubble=1 that cycle and the next.
  - flush_cnt=1.
- Branch and jump together (targets 0x80, 0x200) while a hazard is also asserted:
  - PC=0x80; no stall counted; flush_cnt increments.
- Wrap and saturation:
  - Start at RESET_PC=32'hFFFF_FFF8: PC goes FFFF_FFFC then 0.
  - With CNT_W=2, hold hazard 5 cycles: stall_cnt stays at 3.
- RESET asserted during a stall cycle:
  - next edge: PC=RESET_PC, counters 0, if_id_valid=0.
